scale_job_ctrl: RTL

//  Job sequencer for the image scaling datapath (image_alu + generate_row_col).

---
 rtl/scale_job_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/scale_job_ctrl.sv
// Job sequencer for the image scaling core: validates a scale command, configures the core,
// pulses its reset, runs it until frame_done and flips the display buffer. Option: SCALE_CTRL_WDOG_EN.
module scale_job_ctrl #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int MAX_W   = 640,
  parameter int MAX_H   = 480,
  parameter int RST_CYC = 2
`ifdef SCALE_CTRL_WDOG_EN
  , parameter int WDOG_CYC = 1 << 20
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_algo,
  input  logic [1:0]  cmd_factor,
  input  logic        abort,
  output logic        core_rst_n,
  output logic [1:0]  core_algo_sel,
  output logic [3:0]  core_factor_in,
  output logic [3:0]  core_factor_out,
  output logic [11:0] core_new_w_in,
  output logic [11:0] core_new_h_in,
  output logic [11:0] core_new_w_out,
  output logic [11:0] core_new_h_out,
  input  logic        core_frame_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        buf_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CLR,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);
`ifdef SCALE_CTRL_WDOG_EN
  localparam int WCW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_CYC - 1);
`endif

  state_t         state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
`ifdef SCALE_CTRL_WDOG_EN
  logic [WCW-1:0] wcnt_q, wcnt_d;
`endif
  logic [1:0]  factor_q, factor_d;
  logic [1:0]  algo_q, algo_d;
  logic [3:0]  fin_q, fin_d, fout_q, fout_d;
  logic [11:0] w_in_q, w_in_d, h_in_q, h_in_d;
  logic [11:0] w_out_q, w_out_d, h_out_q, h_out_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        buf_sel_q, buf_sel_d;

  logic       accept;
  logic       zoom_in;
  logic [1:0] sh, sh_in, sh_out;

  assign accept = cmd_valid && cmd_ready_q;

  // Factor code 00/01/10 maps to a shift of 1/2/3; algos 1 and 3 enlarge, 0 and 2 shrink.
  always_comb begin
    zoom_in = cmd_algo[0];
    sh      = (cmd_factor == 2'b11) ? 2'd0 : cmd_factor + 2'd1;
    sh_in   = zoom_in ? sh : 2'd0;
    sh_out  = zoom_in ? 2'd0 : sh;
  end

  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
`ifdef SCALE_CTRL_WDOG_EN
    wcnt_d     = wcnt_q;
`endif
    algo_d     = algo_q;
    factor_d   = factor_q;
    fin_d      = fin_q;
    fout_d     = fout_q;
    w_in_d     = w_in_q;
    h_in_d     = h_in_q;
    w_out_d    = w_out_q;
    h_out_d    = h_out_q;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_CHECK;
          algo_d     = cmd_algo;
          factor_d   = cmd_factor;
          fin_d      = 4'd1 << sh_in;
          fout_d     = 4'd1 << sh_out;
          w_in_d     = 12'(IMG_W) << sh_in;
          h_in_d     = 12'(IMG_H) << sh_in;
          w_out_d    = 12'(IMG_W) >> sh_out;
          h_out_d    = 12'(IMG_H) >> sh_out;
          err_code_d = 2'b00;
        end
      end
      S_CHECK: begin
        if (factor_q == 2'b11) begin
          state_d    = S_ERR;
          err_code_d = 2'b01;
        end else if (algo_q[0] && ((w_in_q > 12'(MAX_W)) || (h_in_q > 12'(MAX_H)))) begin
          state_d    = S_ERR;
          err_code_d = 2'b10;
        end else begin
          state_d = S_CLR;
          rcnt_d  = '0;
        end
      end
      S_CLR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rcnt_q == RST_LAST) begin
          state_d = S_RUN;
`ifdef SCALE_CTRL_WDOG_EN
          wcnt_d  = '0;
`endif
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // A frame completing in the same cycle as an abort still counts as done.
        if (core_frame_done) begin
          state_d = S_DONE;
        end else if (abort) begin
          state_d = S_IDLE;
`ifdef SCALE_CTRL_WDOG_EN
        end else if (wcnt_q == WDOG_LAST) begin
          state_d    = S_ERR;
          err_code_d = 2'b11;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered decodes of the state being entered.
    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d == S_CHECK) || (state_d == S_CLR) || (state_d == S_RUN);
    core_rst_n_d = (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERR);
    buf_sel_d    = buf_sel_q ^ done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rcnt_q       <= '0;
`ifdef SCALE_CTRL_WDOG_EN
      wcnt_q       <= '0;
`endif
      algo_q       <= '0;
      factor_q     <= '0;
      fin_q        <= '0;
      fout_q       <= '0;
      w_in_q       <= '0;
      h_in_q       <= '0;
      w_out_q      <= '0;
      h_out_q      <= '0;
      cmd_ready_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      buf_sel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
`ifdef SCALE_CTRL_WDOG_EN
      wcnt_q       <= wcnt_d;
`endif
      algo_q       <= algo_d;
      factor_q     <= factor_d;
      fin_q        <= fin_d;
      fout_q       <= fout_d;
      w_in_q       <= w_in_d;
      h_in_q       <= h_in_d;
      w_out_q      <= w_out_d;
      h_out_q      <= h_out_d;
      cmd_ready_q  <= cmd_ready_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      buf_sel_q    <= buf_sel_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign core_rst_n      = core_rst_n_q;
  assign core_algo_sel   = algo_q;
  assign core_factor_in  = fin_q;
  assign core_factor_out = fout_q;
  assign core_new_w_in   = w_in_q;
  assign core_new_h_in   = h_in_q;
  assign core_new_w_out  = w_out_q;
  assign core_new_h_out  = h_out_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign err_code        = err_code_q;
  assign buf_sel         = buf_sel_q;

endmodule
